// File: rtl/apb_cmd_master_pkg30.sv
// Shared types and default widths for the apb_cmd_master30 command-to-APB bridge.
package apb_cmd_master_pkg30;

   localparam int unsigned PADDR_WIDTH_DEF30  = 32;
   localparam int unsigned PWDATA_WIDTH_DEF30 = 32;
   localparam int unsigned PRDATA_WIDTH_DEF30 = 32;
   localparam int unsigned SEL_LSB_DEF30      = 12;
   localparam int unsigned TIMEOUT_DEF30      = 256;

   localparam int unsigned PSEL_NUM30   = 16;
   localparam int unsigned PSEL_IDX_W30 = 4;
   localparam int unsigned TOCNT_W30    = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_psel_decode30.sv
// 4-bit slave index to one-hot psel vector; en low forces all lines inactive.
module apb_psel_decode30
   import apb_cmd_master_pkg30::*;
(
   input  logic                    en,
   input  logic [PSEL_IDX_W30-1:0] idx,
   output logic [PSEL_NUM30-1:0]   sel_c
);

   always_comb begin
      sel_c = '0;
      if (en) begin
         sel_c[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_cmd_master30.sv
// Valid/ready command stream to APB master bridge, one transfer outstanding.
// Optional access-phase timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master30
   import apb_cmd_master_pkg30::*;
#(
   parameter int unsigned PADDR_WIDTH30    = PADDR_WIDTH_DEF30,
   parameter int unsigned PWDATA_WIDTH30   = PWDATA_WIDTH_DEF30,
   parameter int unsigned PRDATA_WIDTH30   = PRDATA_WIDTH_DEF30,
   parameter int unsigned SEL_LSB30        = SEL_LSB_DEF30,
   parameter int unsigned TIMEOUT_CYCLES30 = TIMEOUT_DEF30
)
(
   input  logic                      pclock30,
   input  logic                      preset30,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [PADDR_WIDTH30-1:0]  cmd_addr,
   input  logic                      cmd_write,
   input  logic [PWDATA_WIDTH30-1:0] cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [PRDATA_WIDTH30-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [PADDR_WIDTH30-1:0]  paddr30,
   output logic                      prwd30,
   output logic [PWDATA_WIDTH30-1:0] pwdata30,
   output logic [PSEL_NUM30-1:0]     psel30,
   output logic                      penable30,
   input  logic                      pready30,
   input  logic [PRDATA_WIDTH30-1:0] prdata30,
   input  logic                      pslverr30
);

   apb_state_e                state_q, state_d;
   logic [PADDR_WIDTH30-1:0]  paddr_q, paddr_d;
   logic                      prwd_q, prwd_d;
   logic [PWDATA_WIDTH30-1:0] pwdata_q, pwdata_d;
   logic [PSEL_NUM30-1:0]     psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [PRDATA_WIDTH30-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_err_q, rsp_err_d;
   logic                      sel_en_c;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
   logic [TOCNT_W30-1:0]      tocnt_q, tocnt_d;
   logic                      rsp_timeout_q, rsp_timeout_d;
   logic                      to_hit_c;
`else
   logic                      unused_timeout_c;
`endif

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   // Abort when this wait cycle would be the TIMEOUT_CYCLES30-th without pready30.
   assign to_hit_c = (32'(tocnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES30);
`else
   assign unused_timeout_c = ^TIMEOUT_CYCLES30;
`endif

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      prwd_d      = prwd_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      tocnt_d       = tocnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               paddr_d  = cmd_addr;
               prwd_d   = cmd_write;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               tocnt_d  = '0;
`endif
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // pready30 takes priority over a timeout landing on the same cycle.
            if (pready30) begin
               rsp_rdata_d = prwd_q ? '0 : prdata30;
               rsp_err_d   = pslverr30;
               state_d     = RESP;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
            end else if (to_hit_c) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = RESP;
            end else begin
               tocnt_d = tocnt_q + TOCNT_W30'(1);
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus-facing controls follow the next state so they are registered yet cycle-exact.
   assign sel_en_c    = (state_d == SETUP) || (state_d == ACCESS);
   assign penable_d   = (state_d == ACCESS);
   assign rsp_valid_d = (state_d == RESP);
   assign cmd_ready_d = (state_d == IDLE);

   apb_psel_decode30 u_psel_decode (
      .en    (sel_en_c),
      .idx   (paddr_d[SEL_LSB30 +: PSEL_IDX_W30]),
      .sel_c (psel_d)
   );

   always_ff @(posedge pclock30 or negedge preset30) begin
      if (!preset30) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         prwd_q      <= 1'b0;
         pwdata_q    <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
         tocnt_q       <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         prwd_q      <= prwd_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
         tocnt_q       <= tocnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign paddr30   = paddr_q;
   assign prwd30    = prwd_q;
   assign pwdata30  = pwdata_q;
   assign psel30    = psel_q;
   assign penable30 = penable_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master30.sv
// Self-checking bench for apb_cmd_master30: vector table, hand sequences, random traffic.
`timescale 1ns/1ps
module tb_apb_cmd_master30;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam int unsigned TO_CYC = 8;
`else
   localparam int unsigned TO_CYC = 256;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] paddr30;
   logic        prwd30;
   logic [31:0] pwdata30;
   logic [15:0] psel30;
   logic        penable30;
   logic        pready30 = 1'b0;
   logic [31:0] prdata30 = '0;
   logic        pslverr30 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_cmd_master30 #(
      .PADDR_WIDTH30    (32),
      .PWDATA_WIDTH30   (32),
      .PRDATA_WIDTH30   (32),
      .SEL_LSB30        (12),
      .TIMEOUT_CYCLES30 (TO_CYC)
   ) dut (
      .pclock30    (clk),
      .preset30    (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .paddr30     (paddr30),
      .prwd30      (prwd30),
      .pwdata30    (pwdata30),
      .psel30      (psel30),
      .penable30   (penable30),
      .pready30    (pready30),
      .prdata30    (prdata30),
      .pslverr30   (pslverr30)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rd;
      logic        err;
      int          rdly;
      logic [15:0] exp_psel;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string tag, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h @%0t", tag, field, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete command: accept, SETUP, ACCESS with waits, RESP held rdly cycles.
   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                          input logic err, input int rdly, input logic [15:0] exp_psel,
                          input logic [31:0] exp_rdata, input logic exp_err);
      int guard;
      int en_cnt;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      chk(tag, "idle_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_write = wr;
      cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = ~wr;
      chk(tag, "setup_psel", 32'(psel30), 32'(exp_psel));
      chk(tag, "setup_penable", 32'(penable30), 32'd0);
      chk(tag, "setup_paddr", paddr30, addr);
      chk(tag, "setup_prwd", 32'(prwd30), 32'(wr));
      chk(tag, "setup_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      en_cnt = 0;
      for (int i = 0; i <= waits; i++) begin
         chk(tag, "access_psel", 32'(psel30), 32'(exp_psel));
         chk(tag, "access_pwdata", pwdata30, wdata);
         chk(tag, "access_rsp_valid", 32'(rsp_valid), 32'd0);
         if (penable30 === 1'b1) en_cnt++;
         pready30  = (i == waits);
         prdata30  = (i == waits) ? rd : 32'($urandom);
         pslverr30 = (i == waits) ? err : 1'b1;
         tick();
      end
      pready30  = 1'b0;
      prdata30  = $urandom;
      pslverr30 = 1'b1;
      chk(tag, "penable_cycles", 32'(en_cnt), 32'(waits + 1));
      for (int j = 0; j <= rdly; j++) begin
         chk(tag, "rsp_valid", 32'(rsp_valid), 32'd1);
         chk(tag, "rsp_rdata", rsp_rdata, exp_rdata);
         chk(tag, "rsp_err", 32'(rsp_err), 32'(exp_err));
         chk(tag, "rsp_timeout", 32'(rsp_timeout), 32'd0);
         chk(tag, "resp_psel", 32'(psel30), 32'd0);
         chk(tag, "resp_penable", 32'(penable30), 32'd0);
         chk(tag, "resp_cmd_ready", 32'(cmd_ready), 32'd0);
         cmd_valid = (j < rdly);
         rsp_ready = (j == rdly);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk(tag, "done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk(tag, "done_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      logic        r_wr;
      logic [31:0] r_addr;
      logic [31:0] r_rd;
      logic        r_err;
      logic [15:0] m_psel;

      vecs[0] = '{1'b0, 32'h0000_3010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 0, 16'h0008, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_F004, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0, 0, 16'h8000, 32'h0,         1'b0};
      vecs[2] = '{1'b0, 32'h0000_0A20, 32'h0,         1, 32'h0BAD_F00D, 1'b1, 1, 16'h0001, 32'h0BAD_F00D, 1'b1};
      vecs[3] = '{1'b0, 32'h1234_5678, 32'h0,         0, 32'h55AA_55AA, 1'b0, 5, 16'h0020, 32'h55AA_55AA, 1'b0};
      vecs[4] = '{1'b1, 32'hFFFF_7FFC, 32'hA5A5_0F0F, 2, 32'h1111_2222, 1'b1, 2, 16'h0080, 32'h0,         1'b1};

      // Reset values
      repeat (3) @(posedge clk);
      #3;
      chk("reset", "cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset", "rsp_rdata", rsp_rdata, 32'd0);
      chk("reset", "rsp_err", 32'(rsp_err), 32'd0);
      chk("reset", "rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("reset", "paddr", paddr30, 32'd0);
      chk("reset", "prwd", 32'(prwd30), 32'd0);
      chk("reset", "pwdata", pwdata30, 32'd0);
      chk("reset", "psel", 32'(psel30), 32'd0);
      chk("reset", "penable", 32'(penable30), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_reset", "cmd_ready", 32'(cmd_ready), 32'd1);

      for (int v = 0; v < 5; v++) begin
         run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits,
                 vecs[v].rd, vecs[v].err, vecs[v].rdly, vecs[v].exp_psel, vecs[v].exp_rdata,
                 vecs[v].exp_err);
      end

      // Slave never answers
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0000_2000;
      cmd_write = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("hang", "penable", 32'(penable30), 32'd1);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      for (int k = 1; k <= int'(TO_CYC); k++) begin
         tick();
         if (k < int'(TO_CYC)) begin
            chk("timeout", "still_access", 32'(penable30), 32'd1);
         end else begin
            chk("timeout", "rsp_valid", 32'(rsp_valid), 32'd1);
            chk("timeout", "rsp_err", 32'(rsp_err), 32'd1);
            chk("timeout", "rsp_timeout", 32'(rsp_timeout), 32'd1);
            chk("timeout", "rsp_rdata", rsp_rdata, 32'd0);
            chk("timeout", "psel", 32'(psel30), 32'd0);
         end
      end
`else
      repeat (20) tick();
      chk("no_timeout", "penable", 32'(penable30), 32'd1);
      chk("no_timeout", "rsp_valid", 32'(rsp_valid), 32'd0);
      chk("no_timeout", "psel", 32'(psel30), 32'h0004);
      pready30 = 1'b1;
      prdata30 = 32'h600D_D00D;
      pslverr30 = 1'b0;
      tick();
      pready30 = 1'b0;
      chk("no_timeout", "rsp_valid_late", 32'(rsp_valid), 32'd1);
      chk("no_timeout", "rsp_rdata", rsp_rdata, 32'h600D_D00D);
      chk("no_timeout", "rsp_timeout", 32'(rsp_timeout), 32'd0);
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hang", "released", 32'(rsp_valid), 32'd0);

      // Random traffic against the transaction-level model
      for (int n = 0; n < 25; n++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = $urandom;
         r_rd   = $urandom;
         r_err  = 1'($urandom_range(0, 1));
         m_psel = 16'(1) << r_addr[12 +: 4];
         run_txn($sformatf("rnd%0d", n), r_wr, r_addr, 32'($urandom), $urandom_range(0, 4),
                 r_rd, r_err, $urandom_range(0, 3), m_psel, r_wr ? 32'd0 : r_rd, r_err);
      end

      // Reset during ACCESS discards the transfer
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0000_9000;
      cmd_write = 1'b1;
      cmd_wdata = 32'h0F0F_F0F0;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_reset", "pre_psel", 32'(psel30), 32'h0200);
      chk("mid_reset", "pre_penable", 32'(penable30), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", "psel", 32'(psel30), 32'd0);
      chk("mid_reset", "penable", 32'(penable30), 32'd0);
      chk("mid_reset", "rsp_valid", 32'(rsp_valid), 32'd0);
      pready30 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pready30 = 1'b0;
      tick();
      chk("after_reset", "cmd_ready", 32'(cmd_ready), 32'd1);
      chk("after_reset", "rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("after_reset", "no_stale_rsp", 32'(rsp_valid), 32'd0);
      chk("after_reset", "psel", 32'(psel30), 32'd0);

      run_txn("post_reset_txn", 1'b0, 32'h0000_C100, 32'd0, 1, 32'h7777_8888, 1'b0, 0,
              16'h1000, 32'h7777_8888, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case a handshake never completes
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
